// File: rtl/shift_arbiter.sv
// Round-robin arbiter that shares one external combinational 32-bit shifter
// among NUM_REQ requesters, with a single result register (1-cycle latency).
module shift_arbiter #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned RR_W    = $clog2(NUM_REQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  output logic [NUM_REQ-1:0]    o_req_ready,
  input  logic [32*NUM_REQ-1:0] i_req_data,
  input  logic [5*NUM_REQ-1:0]  i_req_amt,
  input  logic [NUM_REQ-1:0]    i_req_dir,
  input  logic [NUM_REQ-1:0]    i_req_arith,
  output logic [NUM_REQ-1:0]    o_rsp_valid,
  input  logic [NUM_REQ-1:0]    i_rsp_ready,
  output logic [31:0]           o_rsp_data,
  output logic [31:0]           o_sh_in,
  output logic [4:0]            o_sh_amt,
  output logic                  o_sh_dir,
  output logic                  o_sh_arith,
  input  logic [31:0]           i_sh_out,
  output logic                  o_busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned AMT_W  = 5;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t            r_state;
  logic [RR_W-1:0]   r_port;
  logic [RR_W-1:0]   r_ptr;
  logic [DATA_W-1:0] r_data;

  logic              w_full;
  logic              w_can_accept;
  logic              w_gnt_vld;
  logic [RR_W-1:0]   w_gnt_idx;
  logic [RR_W-1:0]   w_ptr_nxt;

  assign w_full       = (r_state == ST_FULL);
  // A new result may be loaded when the slot is empty or is being drained now.
  assign w_can_accept = !w_full || i_rsp_ready[r_port];
  assign w_ptr_nxt    = RR_W'((32'(w_gnt_idx) + 32'd1) % NUM_REQ);

  // Round-robin search starting at the pointer; nothing is granted in reset.
  always_comb begin : grant_search
    int unsigned v_idx;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    v_idx     = 0;
    if (w_can_accept && i_rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        v_idx = (32'(r_ptr) + i) % NUM_REQ;
        if (!w_gnt_vld && i_req_valid[RR_W'(v_idx)]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = RR_W'(v_idx);
        end
      end
    end
  end

  // One-hot ready and shifter operand mux for the granted requester.
  always_comb begin
    o_req_ready = '0;
    o_sh_in     = '0;
    o_sh_amt    = '0;
    o_sh_dir    = 1'b0;
    o_sh_arith  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (w_gnt_vld && (w_gnt_idx == RR_W'(k))) begin
        o_req_ready[k] = 1'b1;
        o_sh_in        = i_req_data[DATA_W*k +: DATA_W];
        o_sh_amt       = i_req_amt[AMT_W*k +: AMT_W];
        o_sh_dir       = i_req_dir[k];
        o_sh_arith     = i_req_arith[k];
      end
    end
  end

  // Result register FSM: load on grant, drain on consumer ready, else hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_EMPTY;
      r_port  <= '0;
      r_ptr   <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_gnt_vld) begin
            r_state <= ST_FULL;
            r_port  <= w_gnt_idx;
            r_data  <= i_sh_out;
            r_ptr   <= w_ptr_nxt;
          end
        end
        ST_FULL: begin
          if (w_gnt_vld) begin
            r_port  <= w_gnt_idx;
            r_data  <= i_sh_out;
            r_ptr   <= w_ptr_nxt;
          end else if (i_rsp_ready[r_port]) begin
            r_state <= ST_EMPTY;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  // Response valid is the held port decoded to one-hot, gated by full.
  always_comb begin
    o_rsp_valid = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (w_full && (r_port == RR_W'(k))) o_rsp_valid[k] = 1'b1;
    end
  end

  assign o_rsp_data = r_data;
  assign o_busy     = w_full;

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one combinational 32-bit shifter among NUM_REQ requesters, e.g. the ALU, the load/store byte aligner and the CSR field extractor.
- Each requester gets a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin. One result register sits between the shifter and the requesters, giving 1-cycle latency and up to one shift per cycle.
- The shifter itself is outside this block, connected through the o_sh_*/i_sh_out port group.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- RR_W, $clog2(NUM_REQ), width of the grant pointer and port index; derived, not overridden.

Ports:
- i_clk  input  1  clock, all flops on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req_valid  input  NUM_REQ  per-requester request valid.
- o_req_ready  output  NUM_REQ  per-requester accept; at most one bit set.
- i_req_data  input  32*NUM_REQ  operand; requester k uses bits [32k+31:32k].
- i_req_amt  input  5*NUM_REQ  shift amount.
- i_req_dir  input  NUM_REQ  0 = left, 1 = right.
- i_req_arith  input  NUM_REQ  0 = logical, 1 = arithmetic; ignored when dir = 0.
- o_rsp_valid  output  NUM_REQ  result valid for requester k; at most one bit set.
- i_rsp_ready  input  NUM_REQ  requester k consumes its result.
- o_rsp_data  output  32  shared result bus, qualified by o_rsp_valid.
- o_sh_in  output  32  to shifter: operand.
- o_sh_amt  output  5  to shifter: amount.
- o_sh_dir  output  1  to shifter: 0 = left, 1 = right.
- o_sh_arith  output  1  to shifter: arithmetic select.
- i_sh_out  input  32  from shifter: combinational result of the o_sh_* values.
- o_busy  output  1  result register occupied.

Behaviour:
- **Reset (async, i_rst_n=0):**
  - o_rsp_valid=0, o_rsp_data=0, o_busy=0.
  - Grant pointer=0; result-port index=0.
  - o_req_ready=0 while reset is asserted.
  - A result held at reset time is discarded; no response is emitted for it.
- **State:**
  - Result register {full, port, data}.
  - Round-robin pointer ptr, the highest-priority index.
  - Two states:
    - EMPTY (full=0): no result held.
    - FULL (full=1): a result is held for requester `port`.
- **can_accept:** !full || i_rsp_ready[port].
- **Grant (combinational):**
  - If can_accept, grant the first k with i_req_valid[k] searching ptr, ptr+1, …, wrapping modulo NUM_REQ.
  - o_req_ready is one-hot on the granted k, else 0.
  - o_req_ready may depend combinationally on i_req_valid and i_rsp_ready.
- **Shifter drive:**
  - On a grant, o_sh_* carry the granted requester's fields.
  - With no grant, o_sh_* = 0.
- **Accept edge** (valid & ready for k):
  - full<=1, port<=k, data<=i_sh_out.
  - ptr<=(k+1) mod NUM_REQ.
  - Transition: EMPTY->FULL, or FULL->FULL on a simultaneous drain.
- **Drain without accept:** full && i_rsp_ready[port] and no grant -> full<=0 (FULL->EMPTY); ptr unchanged.
- **Stall:** full && !i_rsp_ready[port] -> register, ptr and o_rsp_data hold; no grant to anyone, including other ports that are ready.
- **Response outputs:**
  - o_rsp_valid = full ? onehot(port) : 0.
  - o_rsp_data = data.
  - o_busy = full.
- **Latency:** accept in cycle t -> o_rsp_valid in cycle t+1. With an always-ready consumer, back-to-back accepts give throughput 1/cycle.
- **Requester rules:**
  - Payload must be held stable while valid && !ready; the block never samples payload without ready.
  - Dropping valid before ready is permitted; nothing is recorded.
- **Ignored input:** i_rsp_ready bits for ports other than `port` are ignored.
- **Shift semantics** are those of the shifter; this block does not alter data. amt=0 returns the operand unchanged.
- **No starvation:** a continuously valid requester is granted within NUM_REQ accept events.

Test Plan:
- **Reset/idle:** assert i_rst_n=0 mid-FULL -> o_rsp_valid=0 and o_busy=0 immediately (async); after release, ptr=0 and requester 0 wins the first contention.
- **Single shift:** req0 data=0x8000_0001, amt=4, dir=1, arith=1 -> ready0 same cycle; next cycle o_rsp_valid=2'b01, o_rsp_data=0xF800_0000. Repeat with arith=0 -> 0x0800_0000; dir=0 -> 0x0000_0010.
- **Round-robin:** both requesters valid continuously, consumers always ready -> grants alternate 0,1,0,1 on consecutive cycles. Results return in grant order, one per cycle, each tagged to the correct port.
- **Backpressure:** result held for port 1 with i_rsp_ready[1]=0 for 5 cycles while req0 is valid -> ready0=0 throughout and o_rsp_data stable. On the cycle rsp_ready[1]=1, req0 is accepted in that same cycle, and its result appears the next cycle.
- **Edge amounts:** amt=0 on 0xDEAD_BEEF returns 0xDEAD_BEEF. amt=31, dir=1, arith=1 on 0x8000_0000 gives 0xFFFF_FFFF; with arith=0 it gives 0x0000_0001.
- **Random soak:** NUM_REQ=4 with random valid/ready and payload stability enforced. Scoreboard per port against a shift model; check one-hot ready/valid, no lost or duplicated results, and starvation bound ≤4 grants.
